// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronises the raw level, debounces it, and
// emits a single-cycle pulse when the debounced level has been held high long enough.
module btn_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 200000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_raw,
  output logic o_btn_db,
  output logic o_hold
);

  localparam int unsigned CntW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CntW-1:0]  CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    StLow,
    StRise,
    StHigh,
    StFall
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic               hold_done_q, hold_done_d;
  logic               btn_db_q, btn_db_d;
  logic               hold_q, hold_d;

  // The FSM only ever looks at the last synchroniser stage.
  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous raw input.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn_raw};
    end
  end

  // Next-state logic for debounce FSM, debounce counter and hold counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_cnt_d  = hold_cnt_q;
    hold_done_d = hold_done_q;
    hold_d      = 1'b0;

    unique case (state_q)
      StLow: begin
        if (sync) begin
          state_d = StRise;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end

      StRise: begin
        if (!sync) begin
          state_d = StLow;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d     = StHigh;
          cnt_d       = '0;
          hold_cnt_d  = '0;
          hold_done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StHigh: begin
        // Hold counting runs on every cycle spent in StHigh, including the
        // one that leaves it; it saturates and fires only once per press.
        if (hold_cnt_q != HoldMax) begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end else if (!hold_done_q) begin
          hold_d      = 1'b1;
          hold_done_d = 1'b1;
        end
        if (!sync) begin
          state_d = StFall;
          cnt_d   = CntW'(1);
        end
      end

      StFall: begin
        // Hold count is frozen here so a release glitch only delays the pulse.
        if (sync) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d     = StLow;
          cnt_d       = '0;
          hold_cnt_d  = '0;
          hold_done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StLow;
        cnt_d   = '0;
      end
    endcase

    btn_db_d = (state_d == StHigh) || (state_d == StFall);
  end

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StLow;
      cnt_q       <= '0;
      hold_cnt_q  <= '0;
      hold_done_q <= 1'b0;
      btn_db_q    <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_done_q <= hold_done_d;
      btn_db_q    <= btn_db_d;
      hold_q      <= hold_d;
    end
  end

  assign o_btn_db = btn_db_q;
  assign o_hold   = hold_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
module tb_btn_debounce;

  logic clk;
  logic rst_n;
  logic btn_raw;
  logic btn_db;
  logic hold;

  int n_checks = 0;
  int n_fail   = 0;
  string cur_tc = "init";

  typedef struct {
    logic db;
    logic hold;
    int   edge_n;
  } exp_t;

  exp_t sb_q[$];

  btn_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10)
  ) u_dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_btn_raw(btn_raw),
    .o_btn_db (btn_db),
    .o_hold   (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue what the outputs must be after the
  // coming edge, then pop and compare once that edge has settled.
  task automatic tick(input logic raw, input logic rst, input logic e_db, input logic e_hold,
                      input int edge_n);
    exp_t e;
    btn_raw = raw;
    rst_n   = rst;
    sb_q.push_back('{db: e_db, hold: e_hold, edge_n: edge_n});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val({cur_tc, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val($sformatf("%s_db_e%0d", cur_tc, e.edge_n), {31'd0, btn_db}, {31'd0, e.db});
      check_val($sformatf("%s_hold_e%0d", cur_tc, e.edge_n), {31'd0, hold}, {31'd0, e.hold});
    end
  endtask

  // Release from a debounced-high state: falls 6 edges after raw=0 is first sampled.
  task automatic release_high(input string tc);
    cur_tc = tc;
    for (int m = 1; m <= 10; m++) tick(1'b0, 1'b1, (m < 6), 1'b0, m);
  endtask

  initial begin
    btn_raw = 1'b1;
    rst_n   = 1'b0;

    // Reset held with raw pressed: outputs stay low.
    cur_tc = "rst";
    for (int n = 1; n <= 3; n++) tick(1'b1, 1'b0, 1'b0, 1'b0, n);
    cur_tc = "rst_rel";
    for (int n = 1; n <= 8; n++) tick(1'b1, 1'b1, (n >= 6), 1'b0, n);
    release_high("rst_fall");

    // Clean long press: single hold pulse at edge 16.
    cur_tc = "long";
    for (int n = 1; n <= 30; n++) tick(1'b1, 1'b1, (n >= 6), (n == 16), n);
    release_high("long_fall");

    // Bounce train 1,1,1,0 x5 never reaches acceptance.
    cur_tc = "bounce";
    for (int n = 1; n <= 20; n++) tick(((n - 1) % 4) < 3, 1'b1, 1'b0, 1'b0, n);
    for (int n = 21; n <= 30; n++) tick(1'b0, 1'b1, 1'b0, 1'b0, n);

    // Release glitch while high: level kept, hold pulse delayed to edge 18.
    cur_tc = "glitch";
    for (int n = 1; n <= 25; n++)
      tick(!(n == 8 || n == 9), 1'b1, (n >= 6), (n == 18), n);
    release_high("glitch_fall");

    // Short press: debounced window edges 6..13, no hold.
    cur_tc = "short";
    for (int n = 1; n <= 20; n++) tick((n <= 8), 1'b1, (n >= 6 && n < 14), 1'b0, n);

    // Reset mid-hold, then a fresh debounce and hold with raw still pressed.
    cur_tc = "midrst";
    for (int n = 1; n <= 11; n++) tick(1'b1, 1'b1, (n >= 6), 1'b0, n);
    for (int n = 12; n <= 13; n++) tick(1'b1, 1'b0, 1'b0, 1'b0, n);
    cur_tc = "midrst_rel";
    for (int m = 1; m <= 20; m++) tick(1'b1, 1'b1, (m >= 6), (m == 16), m);
    release_high("midrst_fall");

    check_val("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditions a raw mechanical push-button input for the alarm system: synchronises it into `i_clk`, rejects contact bounce and drives a clean debounced level.
- Sits directly upstream of the rising-edge pulse generator that triggers the alarm FSM; `o_btn_db` feeds that block's signal input.
- Also flags a long press (arm/disarm hold) with a single-cycle pulse.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `i_btn_raw` (>=2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a level change (>=2; 10 ms at 100 MHz).
- HOLD_CYCLES, 200000000, cycles `o_btn_db` must stay high before `o_hold` fires (>=2; 2 s at 100 MHz).

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  synchronous reset, active-low
- i_btn_raw  input  1  asynchronous raw button level (1 = pressed)
- o_btn_db  output  1  debounced, synchronised button level
- o_hold  output  1  one-cycle pulse on long press

Behaviour:
- One clock; reset is synchronous and active-low: `i_rst_n` sampled on the `i_clk` rising edge.
- Reset state:
  - all synchroniser flops = 0
  - FSM = S_LOW
  - debounce counter and hold counter = 0
  - `o_btn_db` = 0, `o_hold` = 0
- Reset has priority over all other activity and may be asserted mid-operation (mid-count, mid-hold). The block returns fully to the reset state with no residual pulse.
- Synchroniser: SYNC_STAGES-deep flop chain. The FSM only ever sees `sync` (the last stage), never `i_btn_raw`.
- FSM states: S_LOW, S_RISE, S_HIGH, S_FALL. `o_btn_db` is registered and equals 1 exactly while in S_HIGH or S_FALL.
- S_LOW:
  - `sync`=1 -> S_RISE, cnt=1.
  - Otherwise stay, cnt=0.
- S_RISE:
  - `sync`=0 -> S_LOW, cnt=0.
  - `sync`=1 and cnt==DEBOUNCE_CYCLES-1 -> S_HIGH, cnt=0, hold_cnt=0.
  - Otherwise cnt+1.
- S_HIGH:
  - `sync`=0 -> S_FALL, cnt=1.
  - Otherwise hold counting runs.
- S_FALL:
  - `sync`=1 -> S_HIGH, cnt=0; hold_cnt is kept, not cleared.
  - `sync`=0 and cnt==DEBOUNCE_CYCLES-1 -> S_LOW, cnt=0, hold_cnt=0.
  - Otherwise cnt+1.
- Debounce latency: with `i_btn_raw` held stable, `o_btn_db` changes exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges after the first edge that samples the new raw level.
- Any opposite sample during counting restarts acceptance from zero. A bounce train shorter than DEBOUNCE_CYCLES stable samples never changes `o_btn_db`.
- Hold counter:
  - Increments every cycle in S_HIGH and is frozen in S_FALL.
  - When it reaches HOLD_CYCLES-1 in S_HIGH, `o_hold`=1 for exactly one cycle on the next edge, then the counter saturates.
  - At most one `o_hold` pulse per press; re-armed only after the FSM returns to S_LOW.
  - With no bounce, `o_hold` rises HOLD_CYCLES edges after `o_btn_db` rises.
- Counter widths: `$clog2` of the respective parameter, minimum 1. Counters never wrap: compare-and-stop, no overflow.
- `o_hold` and the `o_btn_db` transitions are glitch-free register outputs; no combinational path from `i_btn_raw` to any output.

Test Plan:
- All tests use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
- Reset: `i_rst_n`=0 for 3 edges with `i_btn_raw`=1 -> `o_btn_db`=0 and `o_hold`=0 throughout. After release, `o_btn_db` rises exactly 6 edges after the first post-reset sampling edge.
- Clean long press: raw 0->1 held 30 cycles -> `o_btn_db` rises at edge 6; `o_hold` is a single one-cycle pulse at edge 16 and never repeats while held. On release, `o_btn_db` falls 6 edges after the first edge sampling raw=0.
- Bounce rejection: raw pattern 1,1,1,0 repeated 5 times, then 0 -> `o_btn_db` stays 0 and `o_hold` stays 0.
- Release bounce while high: with `o_btn_db`=1, raw 0 for 2 cycles then 1 -> `o_btn_db` stays 1. The hold count resumes from its frozen value: `o_hold` fires 2 edges later than the no-glitch case, i.e. at edge 18 when the glitch starts at edge 8 (raw=0 sampled at edges 8–9; hold counter frozen while in S_FALL for edges 11–12).
- Short press: raw 1 for 8 cycles -> `o_btn_db` high for the debounced window, `o_hold` never asserts, `o_btn_db` returns to 0.
- Reset mid-hold: assert `i_rst_n`=0 at edge 12 of a long press -> `o_btn_db`=0 next edge and no `o_hold`. After release with raw still 1, a fresh 6-edge debounce precedes `o_btn_db`=1, and `o_hold` fires 10 edges after that.
